// File: rtl/scr1_dmi_ch_ctrl.sv
// -----------------------------------------------------------------------------
// scr1_dmi_ch_ctrl
//
// DTM data-register engine in the core clock domain. It sits behind the TAP
// synchronizer and turns the synchronized capture/shift/update/TDI strobes
// into DTMCS and DMI shift-register activity. A DMI update issues one
// request/response transaction to the Debug Module. Sticky busy status
// follows RISC-V Debug 0.13.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   dmi_ch_sel_i      DTM data channel selected (IR is DTMCS or DMI)
//   ch_id_i           1 = DTMCS, 2 = DMI, other values = bypass
//   ch_capture_i      capture strobe (one clk)
//   ch_shift_i        shift strobe (one clk), ch_tdi_i valid with it
//   ch_update_i       update strobe (one clk)
//   ch_tdo_o          bit 0 of the shift register
//   dmi_req_o         DM request, held until dmi_resp_i
//   dmi_wr_o          1 = write, 0 = read
//   dmi_addr_o        request address
//   dmi_wdata_o       write data
//   dmi_resp_i        one-clk DM response pulse
//   dmi_rdata_i       read data, valid with dmi_resp_i
// -----------------------------------------------------------------------------
module scr1_dmi_ch_ctrl #(
    parameter int unsigned DMI_ABITS  = 7,
    parameter logic [2:0]  DTMCS_IDLE = 3'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dmi_ch_sel_i,
    input  logic [1:0]           ch_id_i,
    input  logic                 ch_capture_i,
    input  logic                 ch_shift_i,
    input  logic                 ch_tdi_i,
    input  logic                 ch_update_i,
    output logic                 ch_tdo_o,
    output logic                 dmi_req_o,
    output logic                 dmi_wr_o,
    output logic [DMI_ABITS-1:0] dmi_addr_o,
    output logic [31:0]          dmi_wdata_o,
    input  logic                 dmi_resp_i,
    input  logic [31:0]          dmi_rdata_i
);

    localparam int unsigned SR_W = DMI_ABITS + 34;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [DMI_ABITS-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 req_q, req_d;
    logic                 wr_q, wr_d;
    logic                 sticky_q, sticky_d;

    logic                 is_dtmcs;
    logic                 is_dmi;
    logic [1:0]           dmistat;
    logic [1:0]           op_st;
    logic [1:0]           upd_op;
    logic [31:0]          dtmcs_cap;
    state_e               state_eff;

    assign is_dtmcs = (ch_id_i == 2'd1);
    assign is_dmi   = (ch_id_i == 2'd2);
    assign dmistat  = sticky_q ? 2'd3 : 2'd0;
    // An in-flight request reports busy even before anything went sticky.
    assign op_st    = (sticky_q || (state_q == ST_REQ)) ? 2'd3 : 2'd0;
    assign upd_op   = sr_q[1:0];

    assign dtmcs_cap = {14'b0, 2'b00, 1'b0, DTMCS_IDLE, dmistat,
                        6'(DMI_ABITS), 4'd1};

    always_comb begin
        sr_d      = sr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wdata_d   = wdata_q;
        req_d     = req_q;
        wr_d      = wr_q;
        sticky_d  = sticky_q;
        state_d   = state_q;
        state_eff = state_q;

        // Shift register: capture has priority over shift.
        if (dmi_ch_sel_i && ch_capture_i) begin
            if (is_dtmcs) begin
                sr_d[31:0] = dtmcs_cap;
            end else if (is_dmi) begin
                sr_d = {addr_q, data_q, op_st};
            end else begin
                sr_d[0] = 1'b0;
            end
        end else if (dmi_ch_sel_i && ch_shift_i) begin
            if (is_dtmcs) begin
                sr_d[31:0] = {ch_tdi_i, sr_q[31:1]};
            end else if (is_dmi) begin
                sr_d = {ch_tdi_i, sr_q[SR_W-1:1]};
            end else begin
                sr_d[0] = ch_tdi_i;
            end
        end

        // A response in the same cycle as an update retires first, so the
        // update below sees the engine as idle.
        if ((state_q == ST_REQ) && dmi_resp_i) begin
            state_d   = ST_IDLE;
            state_eff = ST_IDLE;
            req_d     = 1'b0;
            data_d    = wr_q ? wdata_q : dmi_rdata_i;
        end

        if (dmi_ch_sel_i && ch_update_i) begin
            if (is_dmi) begin
                if (sticky_q || (state_eff == ST_REQ)) begin
                    sticky_d = 1'b1;
                end else if ((upd_op == 2'd1) || (upd_op == 2'd2)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = sr_q[SR_W-1:34];
                    wdata_d = sr_q[33:2];
                    wr_d    = (upd_op == 2'd2);
                end
            end else if (is_dtmcs) begin
                if (sr_q[16]) begin
                    sticky_d = 1'b0;
                end
                // dmihardreset abandons the outstanding request; a late
                // response then lands in IDLE and is ignored.
                if (sr_q[17]) begin
                    sticky_d = 1'b0;
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            sticky_q <= sticky_d;
        end
    end

    assign ch_tdo_o    = sr_q[0];
    assign dmi_req_o   = req_q;
    assign dmi_wr_o    = wr_q;
    assign dmi_addr_o  = addr_q;
    assign dmi_wdata_o = wdata_q;

endmodule

// File: tb/tb_scr1_dmi_ch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scr1_dmi_ch_ctrl
//
// Drives whole DR scans (capture, N shifts, optional update) and DM responses.
// Each is checked against a transaction-level model of the DTM. The model
// tracks the latched address/data, an outstanding-request flag and the sticky
// busy flag.
// -----------------------------------------------------------------------------
module tb_scr1_dmi_ch_ctrl;

    localparam int ABITS = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dmi_ch_sel_i;
    logic [1:0]       ch_id_i;
    logic             ch_capture_i;
    logic             ch_shift_i;
    logic             ch_tdi_i;
    logic             ch_update_i;
    logic             ch_tdo_o;
    logic             dmi_req_o;
    logic             dmi_wr_o;
    logic [ABITS-1:0] dmi_addr_o;
    logic [31:0]      dmi_wdata_o;
    logic             dmi_resp_i;
    logic [31:0]      dmi_rdata_i;

    scr1_dmi_ch_ctrl #(.DMI_ABITS(ABITS), .DTMCS_IDLE(3'd1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmi_ch_sel_i (dmi_ch_sel_i),
        .ch_id_i      (ch_id_i),
        .ch_capture_i (ch_capture_i),
        .ch_shift_i   (ch_shift_i),
        .ch_tdi_i     (ch_tdi_i),
        .ch_update_i  (ch_update_i),
        .ch_tdo_o     (ch_tdo_o),
        .dmi_req_o    (dmi_req_o),
        .dmi_wr_o     (dmi_wr_o),
        .dmi_addr_o   (dmi_addr_o),
        .dmi_wdata_o  (dmi_wdata_o),
        .dmi_resp_i   (dmi_resp_i),
        .dmi_rdata_i  (dmi_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model state
    bit               m_pending;
    bit               m_sticky;
    bit               m_wr;
    logic [ABITS-1:0] m_addr;
    logic [31:0]      m_data;
    logic [31:0]      m_wdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        tick();
        tick();
    endtask

    task automatic strobe(input bit cap, input bit sh, input bit upd, input bit tdi);
        ch_capture_i = cap;
        ch_shift_i   = sh;
        ch_update_i  = upd;
        ch_tdi_i     = tdi;
        tick();
        ch_capture_i = 1'b0;
        ch_shift_i   = 1'b0;
        ch_update_i  = 1'b0;
        ch_tdi_i     = 1'b0;
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_sticky  = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_wdata   = '0;
    endtask

    function automatic int chain_len(input logic [1:0] ch);
        return (ch == 2'd1) ? 32 : (ch == 2'd2) ? (ABITS + 34) : 1;
    endfunction

    // Value a capture should load, from the DTMCS/DMI register layouts.
    function automatic logic [40:0] exp_capture(input logic [1:0] ch);
        int unsigned stat;
        logic [40:0] v;
        stat = m_sticky ? 3 : 0;
        if (ch == 2'd1) begin
            // version 1 | abits << 4 | dmistat << 10 | idle(1) << 12
            v = 41'(1 + (ABITS << 4) + (stat << 10) + (1 << 12));
        end else if (ch == 2'd2) begin
            v = (41'(m_addr) << 34) | (41'(m_data) << 2) |
                ((m_sticky || m_pending) ? 41'd3 : 41'd0);
        end else begin
            v = '0;
        end
        return v;
    endfunction

    task automatic model_update(input logic [1:0] ch, input logic [40:0] v);
        if (ch == 2'd2) begin
            if (m_sticky || m_pending) begin
                m_sticky = 1'b1;
            end else if (v[1:0] == 2'd1 || v[1:0] == 2'd2) begin
                m_pending = 1'b1;
                m_addr    = v[40:34];
                m_wdata   = v[33:2];
                m_wr      = (v[1:0] == 2'd2);
            end
        end else if (ch == 2'd1) begin
            if (v[16] || v[17]) m_sticky = 1'b0;
            if (v[17]) m_pending = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_req"},   64'(dmi_req_o),   64'(m_pending));
        chk({tag, "_wr"},    64'(dmi_wr_o),    64'(m_wr));
        chk({tag, "_addr"},  64'(dmi_addr_o),  64'(m_addr));
        chk({tag, "_wdata"}, 64'(dmi_wdata_o), 64'(m_wdata));
    endtask

    // Full DR scan: capture, shift the whole chain, optionally update.
    task automatic dr(input logic [1:0] ch, input logic [40:0] din, input bit sel,
                      input bit upd, input string tag);
        logic [40:0] dout;
        logic [40:0] exp;
        logic [40:0] mask;
        logic        tdo0;
        int          len;
        len  = chain_len(ch);
        mask = (len >= 41) ? {41{1'b1}} : ((41'd1 << len) - 41'd1);
        exp  = exp_capture(ch);
        tdo0 = ch_tdo_o;
        ch_id_i      = ch;
        dmi_ch_sel_i = sel;
        dout = '0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        gap();
        for (int i = 0; i < len; i++) begin
            dout[i] = ch_tdo_o;
            strobe(1'b0, 1'b1, 1'b0, din[i]);
            gap();
        end
        if (sel) begin
            chk({tag, "_cap"}, 64'(dout & mask), 64'(exp & mask));
            chk({tag, "_tdo"}, 64'(ch_tdo_o), 64'(din[0]));
        end else begin
            chk({tag, "_tdo_hold"}, 64'(ch_tdo_o), 64'(tdo0));
        end
        if (upd) begin
            strobe(1'b0, 1'b0, 1'b1, 1'b0);
            if (sel) model_update(ch, din);
            check_outputs({tag, "_upd"});
            gap();
        end
        dmi_ch_sel_i = 1'b1;
    endtask

    task automatic send_resp(input logic [31:0] rd, input string tag);
        dmi_rdata_i = rd;
        dmi_resp_i  = 1'b1;
        tick();
        dmi_resp_i  = 1'b0;
        dmi_rdata_i = $urandom();
        if (m_pending) begin
            m_pending = 1'b0;
            m_data    = m_wr ? m_wdata : rd;
        end
        check_outputs(tag);
        gap();
    endtask

    function automatic logic [40:0] dmi_word(input logic [ABITS-1:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {a, d, op};
    endfunction

    initial begin
        logic [63:0] rnd;
        logic [40:0] din;
        int          sel_op;

        rst_n        = 1'b0;
        dmi_ch_sel_i = 1'b1;
        ch_id_i      = 2'd0;
        ch_capture_i = 1'b0;
        ch_shift_i   = 1'b0;
        ch_tdi_i     = 1'b0;
        ch_update_i  = 1'b0;
        dmi_resp_i   = 1'b0;
        dmi_rdata_i  = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check_outputs("rst");
        chk("rst_tdo", 64'(ch_tdo_o), 64'd0);

        // DTMCS readout after reset
        dr(2'd1, 41'd0, 1'b1, 1'b0, "dtmcs_rst");

        // DMI write
        dr(2'd2, dmi_word(7'h10, 32'h8000_0001, 2'd2), 1'b1, 1'b1, "wr");
        send_resp(32'h1234_5678, "wr_resp");

        // DMI read, then read back the result
        dr(2'd2, dmi_word(7'h11, 32'h0BAD_F00D, 2'd1), 1'b1, 1'b1, "rd");
        send_resp(32'hDEAD_BEEF, "rd_resp");
        dr(2'd2, 41'd0, 1'b1, 1'b0, "rd_back");

        // Busy: second update during REQ is dropped and goes sticky
        dr(2'd2, dmi_word(7'h05, 32'h0, 2'd1), 1'b1, 1'b1, "busy1");
        dr(2'd2, dmi_word(7'h22, 32'hCAFE_0000, 2'd2), 1'b1, 1'b1, "busy2");
        send_resp(32'h0000_00A5, "busy_resp");
        dr(2'd1, 41'd0, 1'b1, 1'b0, "stat_busy");
        dr(2'd1, 41'(1) << 16, 1'b1, 1'b1, "dmireset");
        dr(2'd1, 41'd0, 1'b1, 1'b0, "stat_clr");
        dr(2'd2, dmi_word(7'h33, 32'h0, 2'd1), 1'b1, 1'b1, "rd_after_clr");
        send_resp(32'h5555_AAAA, "rd_after_clr_resp");

        // dmihardreset during REQ
        dr(2'd2, dmi_word(7'h44, 32'h0, 2'd1), 1'b1, 1'b1, "hr_req");
        dr(2'd1, 41'(1) << 17, 1'b1, 1'b1, "hardreset");
        send_resp(32'hFFFF_0000, "late_resp");
        dr(2'd2, 41'd0, 1'b1, 1'b0, "hr_back");

        // Deselected channel and bypass
        dr(2'd2, dmi_word(7'h55, 32'h1, 2'd1), 1'b0, 1'b1, "nosel");
        dr(2'd3, 41'd1, 1'b1, 1'b1, "byp1");
        dr(2'd3, 41'd0, 1'b1, 1'b1, "byp0");

        // Randomized mix of scans and responses
        for (int it = 0; it < 70; it++) begin
            rnd    = {$urandom(), $urandom()};
            din    = rnd[40:0];
            sel_op = $urandom_range(0, 9);
            if (sel_op <= 3) begin
                dr(2'd2, din, 1'b1, ($urandom_range(0, 3) != 0), "r_dmi");
            end else if (sel_op <= 5) begin
                din[17] = ($urandom_range(0, 3) == 0);
                din[16] = ($urandom_range(0, 1) == 0);
                dr(2'd1, din, 1'b1, 1'b1, "r_dtmcs");
            end else if (sel_op == 6) begin
                dr(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, din, 1'b1, 1'b1, "r_byp");
            end else if (sel_op <= 8) begin
                send_resp($urandom(), "r_resp");
            end else begin
                dr(2'd2, din, 1'b0, 1'b1, "r_nosel");
            end
        end

        // Asynchronous reset with a request outstanding
        if (!m_pending && m_sticky) dr(2'd1, 41'(1) << 16, 1'b1, 1'b1, "pre_arst");
        if (!m_pending) dr(2'd2, dmi_word(7'h66, 32'h0, 2'd1), 1'b1, 1'b1, "arst_req");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        chk("arst_tdo", 64'(ch_tdo_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        dr(2'd2, 41'd0, 1'b1, 1'b0, "post_arst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scr1_dmi_ch_ctrl.md
# scr1_dmi_ch_ctrl

Core-clock DTM data-register engine that sits directly downstream of the TAP-controller synchronizer. It consumes the synchronized capture, shift, update and TDI strobes, plus the channel-select and channel-ID levels. From these it maintains the DTMCS and DMI shift registers and returns TDO. On a DMI update it issues one request/response transaction to the Debug Module and tracks sticky busy status per RISC-V Debug 0.13.

## Interface
- DMI_ABITS, 7: DMI address width; the DMI shift register is DMI_ABITS+34 bits (41).
- DTMCS_IDLE, 3'd1: value reported in DTMCS.idle.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset; one clock, asynchronous active-low reset
- dmi_ch_sel_i  in  1  level; DTM data channel selected (IR = DTMCS or DMI)
- ch_id_i  in  2  level; 2'd1 = DTMCS, 2'd2 = DMI, others = bypass
- ch_capture_i, ch_shift_i  in  1  one-clk pulses (TCK rise)
- ch_tdi_i  in  1  valid together with ch_shift_i
- ch_update_i  in  1  one-clk pulse (TCK fall)
- ch_tdo_o  out  1  bit 0 of the shift register
- dmi_req_o  out  1  DM request; held until the response arrives
- dmi_wr_o  out  1  1 = write, 0 = read; stable while dmi_req_o = 1
- dmi_addr_o  out  DMI_ABITS  request address
- dmi_wdata_o  out  32  write data
- dmi_resp_i  in  1  one-clk DM response pulse
- dmi_rdata_i  in  32  read data; valid with dmi_resp_i

## Operation
- Shift register sr[40:0]. Effective length: 32 (DTMCS), 41 (DMI), 1 (bypass). All strobes are ignored when dmi_ch_sel_i = 0.
- Capture:
  - DTMCS: sr[31:0] <= {14'b0, 2'b00, 1'b0, DTMCS_IDLE, dmistat, 6'(DMI_ABITS), 4'd1}. dmistat = 2'd3 if sticky_busy, else 2'd0.
  - DMI: sr <= {addr_q, data_q, op_st}. op_st = 2'd3 if sticky_busy or state = REQ, else 2'd0.
  - Bypass: sr[0] <= 0.
- Shift: tdi enters at bit (len-1); every bit moves one place toward bit 0. Bits above len-1 hold.
- Capture and shift in the same cycle: capture wins.
- FSM with two states, IDLE and REQ:
  - IDLE -> REQ: DMI update with sr[1:0] = 1 (read) or 2 (write) and sticky_busy = 0. On entry: addr_q <= sr[40:34], dmi_wdata_o <= sr[33:2], dmi_wr_o <= (op = 2).
  - REQ -> IDLE: on dmi_resp_i. data_q <= dmi_rdata_i if the request was a read; otherwise data_q keeps the written data.
- DMI update with op 0 or 3: no request.
- DMI update while in REQ, or any DMI update while sticky_busy = 1: the request is dropped and sticky_busy <= 1.
- DTMCS update:
  - sr[16] (dmireset): clears sticky_busy.
  - sr[17] (dmihardreset): clears sticky_busy, forces IDLE, deasserts dmi_req_o. A response that arrives later in IDLE is ignored.
- Update on bypass: no effect.
- dmi_addr_o = addr_q.

## Timing
- Reset values: sr, addr_q, data_q, dmi_wdata_o = 0; dmi_req_o, dmi_wr_o = 0; sticky_busy = 0; state IDLE; ch_tdo_o = 0.
- All outputs are registered. sr changes 1 clk after a capture or shift pulse, and ch_tdo_o reflects the change in that same cycle.
- dmi_req_o rises 1 clk after an accepted update pulse. It falls 1 clk after dmi_resp_i.
- dmi_resp_i in the same cycle as a DMI update: the response completes first, then the update is treated as an IDLE update. A new request is issued one cycle later.
- dmi_resp_i in IDLE: ignored, with no change to data_q.
- Reset mid-request: dmi_req_o drops asynchronously.
- Strobes are single-cycle with at least 2 clk between them (the synchronizer guarantees this). Back-to-back strobes are still handled per cycle with no loss.

## Test plan
- After reset, capture DTMCS (ch_id = 1), then 32 shifts with tdi = 0 -> TDO bit stream equals 0x00001071 LSB-first (DTMCS_IDLE = 1, abits = 7, version = 1).
- DMI write: shift 41 bits {addr 7'h10, data 0x8000_0001, op 2}, then update -> dmi_req_o = 1 next clk with dmi_wr_o = 1, dmi_addr_o = 0x10, dmi_wdata_o = 0x8000_0001. dmi_req_o falls 1 clk after dmi_resp_i.
- DMI read of addr 0x11; DM returns 0xDEADBEEF; then capture and shift out -> TDO stream gives op 0, data 0xDEADBEEF, addr 0x11.
- Second DMI update while dmi_req_o = 1 -> no second request. Next capture gives op 3 and DTMCS dmistat = 3. DTMCS update with dmireset = 1 -> dmistat = 0, and a new DMI read is accepted.
- DTMCS update with dmihardreset = 1 during REQ -> dmi_req_o = 0 next clk; a later dmi_resp_i leaves data_q unchanged.
- Strobes with dmi_ch_sel_i = 0, or ch_id = 3 with update -> no request; bypass captures 0 and shifts tdi to TDO after 1 shift.
